// File: rtl/irq_pending_latch.sv
// irq_pending_latch: synchronises eight request lines, latches their rising edges as sticky
// pending bits, and runs the irq raise / ack / one-cycle-gap handshake for the priority encoder.
module irq_pending_latch #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  input  logic       ack,
  input  logic [2:0] ack_id,
  input  logic       ovf_clr,
  output logic [7:0] pend,
  output logic       irq,
  output logic [7:0] ovf,
  output logic       ack_err
);
  typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
  logic [7:0] hist_q, hist_d, pending_q, pending_d, ovf_q, ovf_d, edges, clr;
  logic irq_q, irq_d, ack_err_q, ack_err_d, ack_ok;
  assign pend    = pending_q & mask;
  assign irq     = irq_q;
  assign ovf     = ovf_q;
  assign ack_err = ack_err_q;
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], req};
    hist_d    = sync_q[SYNC_STAGES-1];
    edges     = sync_q[SYNC_STAGES-1] & ~hist_q;
    ack_ok    = (state_q == ASSERT) && ack;
    clr       = (ack_ok && pending_q[ack_id]) ? (8'd1 << ack_id) : 8'h00;
    // a new edge beats a same-cycle clear, and that case is not an overflow
    pending_d = (pending_q & ~clr) | edges;
    ovf_d     = (ovf_clr ? 8'h00 : ovf_q) | (edges & pending_q & ~clr);
    ack_err_d = ack_ok && !pending_q[ack_id];
    state_d   = (state_q == ASSERT && ack) ? GAP : (|pend ? ASSERT : IDLE);
    irq_d     = state_d == ASSERT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      hist_q    <= '0;
      pending_q <= '0;
      ovf_q     <= '0;
      ack_err_q <= 1'b0;
      irq_q     <= 1'b0;
      state_q   <= IDLE;
    end else begin
      sync_q    <= sync_d;
      hist_q    <= hist_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      ack_err_q <= ack_err_d;
      irq_q     <= irq_d;
      state_q   <= state_d;
    end
  end
endmodule

// File: tb/tb_irq_pending_latch.sv
// tb_irq_pending_latch: directed plus random stimulus against a request-history model,
// expected outputs queued per cycle and checked by an independent monitor.
module tb_irq_pending_latch;
  localparam int SYNC = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] req = '0, mask = '0;
  logic ack = 1'b0, ovf_clr = 1'b0;
  logic [2:0] ack_id = '0;
  logic [7:0] pend, ovf;
  logic irq, ack_err;
  typedef struct packed {
    logic [7:0] pend;
    logic       irq;
    logic [7:0] ovf;
    logic       ack_err;
  } exp_t;
  exp_t sb[$];
  exp_t x;
  int errors = 0, checks = 0;
  logic [7:0] hq[$];
  logic [7:0] m_pnd = '0, m_ovf = '0;
  logic m_err = 1'b0;
  int m_phase = 0;
  logic [7:0] r, mk;
  logic [2:0] id;

  irq_pending_latch #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .ack(ack), .ack_id(ack_id),
    .ovf_clr(ovf_clr), .pend(pend), .irq(irq), .ovf(ovf), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", n, got, want, $time);
    end
  endtask

  // phase: 0 no irq, 1 irq raised, 2 post-ack gap
  task automatic step(input logic rn, input logic [7:0] rq, input logic [7:0] m,
                      input logic a, input logic [2:0] i, input logic c);
    logic [7:0] e, clrm, pm;
    logic ok;
    @(negedge clk);
    rst_n = rn; req = rq; mask = m; ack = a; ack_id = i; ovf_clr = c;
    if (!rn) begin
      m_pnd = '0; m_ovf = '0; m_err = 1'b0; m_phase = 0;
      hq.delete();
      repeat (SYNC + 1) hq.push_back(8'h00);
    end
    #1 sb.push_back('{m_pnd & m, m_phase == 1, m_ovf, m_err});
    if (rn) begin
      e = hq[1] & ~hq[0];
      hq.push_back(rq);
      void'(hq.pop_front());
      pm = m_pnd & m;
      ok = a && m_phase == 1;
      clrm = (ok && m_pnd[i]) ? 8'(1 << i) : 8'h00;
      m_err = ok && !m_pnd[i];
      m_ovf = (c ? 8'h00 : m_ovf) | (e & m_pnd & ~clrm);
      m_pnd = (m_pnd & ~clrm) | e;
      m_phase = (m_phase == 1 && a) ? 2 : (pm != 0 ? 1 : 0);
    end
  endtask

  task automatic idle(input int n, input logic [7:0] rq, input logic [7:0] m);
    repeat (n) step(1'b1, rq, m, 1'b0, 3'd0, 1'b0);
  endtask

  always @(negedge clk) begin
    #2;
    if (sb.size() != 0) begin
      x = sb.pop_front();
      chk("pend", pend, x.pend);
      chk("irq", {7'd0, irq}, {7'd0, x.irq});
      chk("ovf", ovf, x.ovf);
      chk("ack_err", {7'd0, ack_err}, {7'd0, x.ack_err});
    end
  end

  initial begin
    repeat (3) step(1'b0, 8'h01, 8'hFF, 1'b0, 3'd0, 1'b0);
    idle(6, 8'h01, 8'hFF);
    step(1'b1, 8'h01, 8'hFF, 1'b1, 3'd0, 1'b0);
    idle(3, 8'h01, 8'hFF);
    idle(6, 8'h21, 8'hFF);
    step(1'b1, 8'h21, 8'hFF, 1'b1, 3'd5, 1'b0);
    idle(3, 8'h21, 8'hFF);
    idle(6, 8'h65, 8'hFF);
    step(1'b1, 8'h65, 8'hFF, 1'b1, 3'd6, 1'b0);
    idle(2, 8'h65, 8'hFF);
    step(1'b1, 8'h65, 8'hFF, 1'b1, 3'd2, 1'b0);
    idle(3, 8'h65, 8'hFF);
    idle(6, 8'h6D, 8'hF7);
    idle(2, 8'h6D, 8'hFF);
    idle(3, 8'h6D, 8'h00);
    idle(2, 8'h6D, 8'hFF);
    step(1'b1, 8'h6D, 8'hFF, 1'b1, 3'd0, 1'b0);
    idle(3, 8'h6D, 8'hFF);
    idle(5, 8'h6F, 8'hFF);
    idle(2, 8'h6D, 8'hFF);
    idle(5, 8'h6F, 8'hFF);
    step(1'b1, 8'h6F, 8'hFF, 1'b0, 3'd0, 1'b1);
    idle(2, 8'h6D, 8'hFF);
    idle(2, 8'h6F, 8'hFF);
    step(1'b1, 8'h6F, 8'hFF, 1'b1, 3'd1, 1'b0);
    idle(4, 8'h6F, 8'hFF);
    r = 8'h6F;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 1) == 0) r = r ^ 8'(1 << $urandom_range(0, 7));
      mk = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFF;
      id = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0)
        for (int b = 7; b >= 0; b--) if (m_pnd[b]) id = 3'(b);
      step($urandom_range(0, 499) != 0, r, mk, $urandom_range(0, 2) == 0, id,
           $urandom_range(0, 9) == 0);
    end
    idle(3, r, 8'hFF);
    @(negedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d expected=0 pending expectations", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
